pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Sequences the five-stage pipeline around the decode control unit.
- Consumes decoded control bits carried into EX: mem_read, branch, plus register indices.
- Drives per-stage write-enable, bubble and flush signals for load-use hazards, data-cache waits and taken branches/jumps.
- Keeps a stall performance counter and a sticky memory-timeout flag. Sits beside the decode stage in the core top.

Parameters:
- LOAD_USE_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, maximum consecutive DMEM_WAIT cycles before mem_timeout sets (1..65535).
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R, S, branch types)
- ex_rd  in  5  destination index of instruction in EX
- ex_mem_read  in  1  EX instruction is a load (control unit mem_read, pipelined)
- ex_branch  in  1  EX instruction is branch/jump (control unit branch, pipelined)
- ex_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage has a valid load/store
- mem_ready  in  1  data cache completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID cleared to NOP at next edge
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  ID/EX loaded with NOP (all control bits 0)
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_bubble  out  1  MEM/WB loaded with NOP
- stall_count  out  CNT_W  cycles with pc_write=0 since reset
- mem_timeout  out  1  sticky error flag

Behaviour:
- Four-state FSM, registered: RUN, LOAD_STALL, DMEM_WAIT, ERROR. All outputs are combinational from state and current inputs; nothing is registered except state, counters and mem_timeout.
- Reset (async): state=RUN, stall_cnt=0, wait_cnt=0, stall_count=0, mem_timeout=0. Outputs then read as all enables 1, all bubbles/flushes 0.
- Default (RUN, no event): all *_write=1, all bubble/flush=0.
- Hazard is defined as: ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
- Priority each cycle: dmem wait > branch flush > load-use.
- DMEM wait: in RUN, if mem_req && !mem_ready, go to DMEM_WAIT. In that cycle and throughout DMEM_WAIT: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1.
  - DMEM_WAIT: wait_cnt increments each cycle. When mem_ready=1, outputs revert to RUN defaults that same cycle, go to RUN, and wait_cnt clears.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready=0, set mem_timeout and go to ERROR.
  - mem_ready in the same cycle as mem_req causes no stall.
- Branch flush (RUN only): ex_branch && ex_taken drives if_id_flush=1 and id_ex_bubble=1 that cycle. Enables stay 1 and state stays RUN; penalty is 2 cycles, no counting state. A taken branch during DMEM_WAIT is held, because EX is frozen; it is acted on in the cycle DMEM_WAIT exits.
- Load-use (RUN only, no dmem wait, no taken branch): pc_write=if_id_write=0, id_ex_bubble=1, EX/MEM continues.
  - If LOAD_USE_CYCLES>1, go to LOAD_STALL with stall_cnt=LOAD_USE_CYCLES-1. LOAD_STALL holds the same outputs and decrements stall_cnt, returning to RUN when it reaches 0.
  - A dmem wait arising in LOAD_STALL preempts it: go to DMEM_WAIT and drop the remaining load-use count; the hazard recomputes on return.
  - Hazard and taken branch in the same cycle: flush only, no stall.
- ERROR: all enables 0, mem_wb_bubble=1. Leaves only via reset.
- stall_count increments on every cycle with pc_write=0, including ERROR, and saturates at all-ones. Reset mid-operation clears all state immediately.
- rd=x0 never causes a hazard.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_IDX_W=5
  - ZERO_REG=5'd0
  - FSM state encoding (RUN=2'd0, LOAD_STALL=2'd1, DMEM_WAIT=2'd2, ERROR=2'd3)
  - NOP instruction constant used by the stage registers
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count, saturating), instantiated for stall_count.
- The hazard compare and FSM stay inline.

Test Plan:
- Reset asserted mid-DMEM_WAIT (wait_cnt=10) -> next sample: all enables 1, stall_count=0, mem_timeout=0.
- ex_mem_read=1, ex_rd=5, id_rs1=5, LOAD_USE_CYCLES=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; then RUN; stall_count=1. Repeat with ex_rd=0 -> no stall.
- id_rs2=7, id_uses_rs2=0, ex_rd=7, ex_mem_read=1 -> no stall. Same with id_uses_rs2=1 -> stall.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all enables 0 and mem_wb_bubble=1 for 3 cycles; released in the mem_ready cycle; stall_count=3.
- ex_branch=1, ex_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall. ex_taken=0 -> no flush.
- MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> mem_timeout=1 after 4 wait cycles, state ERROR, enables stay 0 until reset.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline sequencing logic: register index width,
// the x0 index, FSM state encoding and the NOP used by the stage registers.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_DMEM_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERROR      = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count qualified cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: per-stage enables, bubbles and flushes for data-cache
// waits, taken branches and load-use hazards, plus stall statistics.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch,
  input  logic                 ex_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_write,
  output logic                 mem_wb_bubble,
  output logic [CNT_W-1:0]     stall_count,
  output logic                 mem_timeout
);

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  logic [2:0]  stall_cnt_r;
  logic [2:0]  stall_cnt_nxt_s;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_cnt_nxt_s;
  logic        mem_timeout_r;
  logic        timeout_set_s;
  logic        hazard_s;
  logic        dmem_miss_s;
  logic        run_eval_s;
  logic        start_wait_s;

  assign hazard_s = ex_mem_read && (ex_rd != ZERO_REG) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign dmem_miss_s = mem_req && !mem_ready;

  // Next-state and stage-control decode; priority is dmem wait, then branch flush, then load-use.
  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_write     = 1'b1;
    id_ex_bubble    = 1'b0;
    ex_mem_write    = 1'b1;
    mem_wb_bubble   = 1'b0;
    next_state_s    = state_r;
    stall_cnt_nxt_s = stall_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    timeout_set_s   = 1'b0;
    run_eval_s      = 1'b0;
    start_wait_s    = 1'b0;

    case (state_r)
      ST_RUN: begin
        run_eval_s = 1'b1;
      end
      ST_LOAD_STALL: begin
        if (dmem_miss_s) begin
          start_wait_s = 1'b1;
        end else begin
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
          id_ex_bubble    = 1'b1;
          stall_cnt_nxt_s = stall_cnt_r - 3'd1;
          next_state_s    = (stall_cnt_r <= 3'd1) ? ST_RUN : ST_LOAD_STALL;
        end
      end
      ST_DMEM_WAIT: begin
        // A held branch or hazard in EX/ID is acted on in the release cycle.
        if (mem_ready) begin
          run_eval_s     = 1'b1;
          wait_cnt_nxt_s = 16'd0;
          next_state_s   = ST_RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          if (wait_cnt_r >= 16'(MEM_TIMEOUT - 1)) begin
            timeout_set_s = 1'b1;
            next_state_s  = ST_ERROR;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 16'd1;
          end
        end
      end
      ST_ERROR: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase

    if (run_eval_s) begin
      if (dmem_miss_s) begin
        start_wait_s = 1'b1;
      end else if (ex_branch && ex_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard_s) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          next_state_s    = ST_LOAD_STALL;
          stall_cnt_nxt_s = 3'(LOAD_USE_CYCLES - 1);
        end else begin
          next_state_s    = ST_RUN;
        end
      end else begin
        if_id_flush = 1'b0;
      end
    end else begin
      run_eval_s = 1'b0;
    end

    // The miss cycle itself is the first wait cycle.
    if (start_wait_s) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_write     = 1'b0;
      id_ex_bubble    = 1'b0;
      ex_mem_write    = 1'b0;
      mem_wb_bubble   = 1'b1;
      stall_cnt_nxt_s = 3'd0;
      if (MEM_TIMEOUT <= 1) begin
        timeout_set_s = 1'b1;
        next_state_s  = ST_ERROR;
      end else begin
        next_state_s   = ST_DMEM_WAIT;
        wait_cnt_nxt_s = 16'd1;
      end
    end else begin
      start_wait_s = 1'b0;
    end
  end

  // State, load-use and wait counters, sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      stall_cnt_r   <= 3'd0;
      wait_cnt_r    <= 16'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  assign mem_timeout = mem_timeout_r;

  sat_counter #(.W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomised and directed bench for pipeline_controller with a scoreboard fed
// by a counter-based reference model of the sequencing rules.
module tb_pipeline_controller;

  localparam int L_CYC = 2;
  localparam int MT    = 12;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       tk;
    logic       mq;
    logic       my;
  } stim_t;

  typedef struct {
    logic [6:0] ctrl;
    int         scount;
    logic       tout;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch = 1'b0, ex_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_count;

  pipeline_controller #(.LOAD_USE_CYCLES(L_CYC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: wait length, remaining load-use bubbles, dead flag.
  int  m_wlen = 0;
  int  m_lu = 0;
  bit  m_dead = 0;
  int  m_scount = 0;
  bit  m_tflag = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input stim_t s, input bit r);
    exp_t e;
    bit hz, miss, start;
    int kind;  // 0 run, 1 flush, 2 load-use stall, 3 freeze
    int nwlen, nlu;
    bit ndead, ntf;
    if (r) begin
      m_wlen = 0; m_lu = 0; m_dead = 0; m_scount = 0; m_tflag = 0;
    end
    hz = s.mr && (s.rd != 5'd0) && ((s.rd == s.rs1) || (s.u2 && (s.rd == s.rs2)));
    miss = s.mq && !s.my;
    start = 0; kind = 0;
    nwlen = m_wlen; nlu = m_lu; ndead = m_dead; ntf = m_tflag;
    if (m_dead) begin
      kind = 3;
    end else if (m_wlen > 0 && !s.my) begin
      kind = 3;
      if (m_wlen + 1 >= MT) begin ndead = 1; ntf = 1; end
      else nwlen = m_wlen + 1;
    end else begin
      nwlen = 0;
      if (m_lu > 0) begin
        if (miss) start = 1;
        else begin kind = 2; nlu = m_lu - 1; end
      end else if (miss) start = 1;
      else if (s.br && s.tk) kind = 1;
      else if (hz) begin kind = 2; nlu = L_CYC - 1; end
    end
    if (start) begin
      kind = 3; nlu = 0;
      if (MT <= 1) begin ndead = 1; ntf = 1; end
      else nwlen = 1;
    end
    case (kind)
      1:       e.ctrl = 7'b1111110;
      2:       e.ctrl = 7'b0001110;
      3:       e.ctrl = 7'b0000001;
      default: e.ctrl = 7'b1101010;
    endcase
    e.scount = m_scount;
    e.tout = m_tflag;
    q.push_back(e);
    if (!r) begin
      m_wlen = nwlen; m_lu = nlu; m_dead = ndead; m_tflag = ntf;
      if (!e.ctrl[6] && m_scount < CMAX) m_scount++;
    end
  endtask

  task automatic tick(input stim_t s, input bit r);
    @(posedge clk);
    #1;
    reset = r;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs2 = s.u2; ex_rd = s.rd;
    ex_mem_read = s.mr; ex_branch = s.br; ex_taken = s.tk;
    mem_req = s.mq; mem_ready = s.my;
    model_step(s, r);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.my = 1'b1;
    return s;
  endfunction

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", int'({pc_write, if_id_write, if_id_flush, id_ex_write,
                          id_ex_bubble, ex_mem_write, mem_wb_bubble}), int'(e.ctrl));
        chk("stall_count", int'(stall_count), e.scount);
        chk("mem_timeout", int'(mem_timeout), int'(e.tout));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    tick(s, 1'b1);
    tick(s, 1'b1);
    repeat (3) tick(idle(), 1'b0);

    // Load-use through rs1, then x0 destination
    s = idle(); s.mr = 1; s.rd = 5'd5; s.rs1 = 5'd5;
    tick(s, 1'b0); tick(s, 1'b0); tick(idle(), 1'b0);
    s.rd = 5'd0; s.rs1 = 5'd0;
    tick(s, 1'b0); tick(idle(), 1'b0);

    // rs2 only counts when the instruction reads it
    s = idle(); s.mr = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.rs1 = 5'd1; s.u2 = 0;
    tick(s, 1'b0);
    s.u2 = 1;
    tick(s, 1'b0); tick(s, 1'b0); tick(idle(), 1'b0);

    // Three-cycle cache miss
    s = idle(); s.mq = 1; s.my = 0;
    repeat (3) tick(s, 1'b0);
    s.my = 1;
    tick(s, 1'b0); tick(idle(), 1'b0);

    // Taken branch beats load-use; untaken branch does nothing
    s = idle(); s.br = 1; s.tk = 1; s.mr = 1; s.rd = 5'd3; s.rs1 = 5'd3;
    tick(s, 1'b0);
    s.tk = 0; s.mr = 0;
    tick(s, 1'b0);

    // Taken branch held across a miss, applied on release
    s = idle(); s.br = 1; s.tk = 1; s.mq = 1; s.my = 0;
    tick(s, 1'b0); tick(s, 1'b0);
    s.my = 1;
    tick(s, 1'b0); tick(idle(), 1'b0);

    // Miss arriving during the load-use stall preempts it
    s = idle(); s.mr = 1; s.rd = 5'd9; s.rs1 = 5'd9;
    tick(s, 1'b0);
    s.mq = 1; s.my = 0;
    tick(s, 1'b0); tick(s, 1'b0);
    s.my = 1;
    tick(s, 1'b0); tick(idle(), 1'b0);

    // Reset in the middle of a long miss
    s = idle(); s.mq = 1; s.my = 0;
    repeat (11) tick(s, 1'b0);
    tick(idle(), 1'b1);
    repeat (2) tick(idle(), 1'b0);

    // Timeout, error lock-up and counter saturation
    s = idle(); s.mq = 1; s.my = 0;
    repeat (MT + 3) tick(s, 1'b0);
    repeat (CMAX + 20) tick(idle(), 1'b0);
    tick(idle(), 1'b1);
    repeat (2) tick(idle(), 1'b0);

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u2  = 1'($urandom_range(0, 1));
      s.mr  = ($urandom_range(0, 99) < 40);
      s.br  = ($urandom_range(0, 99) < 20);
      s.tk  = 1'($urandom_range(0, 1));
      s.mq  = ($urandom_range(0, 99) < 30);
      s.my  = ($urandom_range(0, 99) < 70);
      tick(s, ($urandom_range(0, 399) == 0));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
